// File: rtl/vliw_bypass_ctrl_pkg.sv
// Shared constants and the per-lane in-flight tag for the VLIW bypass controller.
package vliw_pkg;

    localparam int REG_AW = 5;
    localparam int FWD_RF = 0;

    // One issue slot's destination as it travels down the bypass pipeline.
    typedef struct packed {
        logic              wr;
        logic [REG_AW-1:0] rd;
        logic              ld;
    } lane_tag_t;

endpackage

// File: rtl/vliw_bypass_ctrl_if.sv
// Issue-side bundle bus between the issuer (master) and the bypass controller (slave).
interface vliw_bypass_ctrl_if #(
    parameter int LANES  = 2,
    parameter int SRCS   = 2,
    parameter int DEPTH  = 2,
    parameter int REG_AW = vliw_pkg::REG_AW
);
    localparam int SELW = $clog2(LANES*DEPTH+1);

    logic                         issue_valid;
    logic [LANES*SRCS*REG_AW-1:0] issue_rs;
    logic [LANES*SRCS-1:0]        issue_rs_used;
    logic [LANES*REG_AW-1:0]      issue_rd;
    logic [LANES-1:0]             issue_wr;
    logic [LANES-1:0]             issue_ld;
    logic                         flush;
    logic                         stall;
    logic [LANES*SRCS*SELW-1:0]   fwd_sel;
    logic                         bundle_conflict;
    logic [15:0]                  stall_cnt;

    modport master (
        output issue_valid, issue_rs, issue_rs_used, issue_rd, issue_wr, issue_ld, flush,
        input  stall, fwd_sel, bundle_conflict, stall_cnt
    );

    modport slave (
        input  issue_valid, issue_rs, issue_rs_used, issue_rd, issue_wr, issue_ld, flush,
        output stall, fwd_sel, bundle_conflict, stall_cnt
    );

endinterface

// File: rtl/vliw_bypass_ctrl_fwd_match.sv
// Matches one source operand against every in-flight lane tag and picks its bypass source.
module fwd_match #(
    parameter int LANES  = 2,
    parameter int DEPTH  = 2,
    parameter int REG_AW = vliw_pkg::REG_AW,
    parameter int SELW   = $clog2(LANES*DEPTH+1)
) (
    input  logic                                   i_used,
    input  logic [REG_AW-1:0]                      i_rs,
    input  vliw_pkg::lane_tag_t [DEPTH*LANES-1:0]  i_tags,
    output logic [SELW-1:0]                        o_sel,
    output logic                                   o_ld_hit
);
    import vliw_pkg::*;

    // Scan oldest stage first so the youngest stage overwrites; within a stage the highest lane wins.
    always_comb begin
        o_sel    = SELW'(FWD_RF);
        o_ld_hit = 1'b0;
        if (i_used && (i_rs != '0)) begin
            for (int s = DEPTH-1; s >= 0; s--) begin
                for (int l = 0; l < LANES; l++) begin
                    if (i_tags[s*LANES+l].wr && (i_tags[s*LANES+l].rd == i_rs)) begin
                        o_sel    = SELW'(s*LANES + l + 1);
                        o_ld_hit = (s == 0) && i_tags[s*LANES+l].ld;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/vliw_bypass_ctrl.sv
// VLIW bypass controller: tracks in-flight destinations, selects forwarding sources, detects load-use stalls.
module vliw_bypass_ctrl #(
    parameter int LANES  = 2,
    parameter int SRCS   = 2,
    parameter int DEPTH  = 2,
    parameter int REG_AW = vliw_pkg::REG_AW
) (
    input logic               clk,
    input logic               rst,
    vliw_bypass_ctrl_if.slave bus
);
    import vliw_pkg::*;

    localparam int SELW = $clog2(LANES*DEPTH+1);
    localparam int NTAG = LANES*DEPTH;
    localparam int NOPS = LANES*SRCS;

    lane_tag_t [NTAG-1:0]  r_tags;
    logic                  r_conflict;
    logic [15:0]           r_stall_cnt;

    lane_tag_t [LANES-1:0] w_new;
    logic [NOPS-1:0]       w_ld_hit;
    logic [NOPS*SELW-1:0]  w_fwd_sel;
    logic                  w_stall;
    logic                  w_accept;
    logic                  w_conflict;

    // Operands are masked during reset so nothing matches and no stall is raised.
    for (genvar k = 0; k < NOPS; k++) begin : g_op
        fwd_match #(
            .LANES  (LANES),
            .DEPTH  (DEPTH),
            .REG_AW (REG_AW),
            .SELW   (SELW)
        ) u_match (
            .i_used   (bus.issue_rs_used[k] & ~rst),
            .i_rs     (bus.issue_rs[k*REG_AW +: REG_AW]),
            .i_tags   (r_tags),
            .o_sel    (w_fwd_sel[k*SELW +: SELW]),
            .o_ld_hit (w_ld_hit[k])
        );
    end

    assign w_stall  = bus.issue_valid & ~bus.flush & (|w_ld_hit);
    assign w_accept = bus.issue_valid & ~bus.flush & ~w_stall;

    // Build the presented bundle's lane tags and flag two lanes writing the same nonzero register.
    always_comb begin
        w_conflict = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            w_new[l].wr = bus.issue_wr[l];
            w_new[l].rd = bus.issue_rd[l*REG_AW +: REG_AW];
            w_new[l].ld = bus.issue_ld[l];
        end
        for (int a = 0; a < LANES; a++) begin
            for (int b = a + 1; b < LANES; b++) begin
                if (bus.issue_wr[a] && bus.issue_wr[b] &&
                    (bus.issue_rd[a*REG_AW +: REG_AW] == bus.issue_rd[b*REG_AW +: REG_AW]) &&
                    (bus.issue_rd[a*REG_AW +: REG_AW] != '0)) begin
                    w_conflict = 1'b1;
                end
            end
        end
    end

    // Advance the tag pipeline; a flush turns the current EX entry into a bubble as it moves on.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tags <= '0;
        end else begin
            for (int s = DEPTH-1; s >= 1; s--) begin
                for (int l = 0; l < LANES; l++) begin
                    r_tags[s*LANES+l] <= ((s == 1) && bus.flush) ? lane_tag_t'('0)
                                                                 : r_tags[(s-1)*LANES+l];
                end
            end
            for (int l = 0; l < LANES; l++) begin
                r_tags[l] <= w_accept ? w_new[l] : lane_tag_t'('0);
            end
        end
    end

    // Register the conflict pulse and keep a saturating count of stall cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_conflict  <= 1'b0;
            r_stall_cnt <= 16'h0000;
        end else begin
            r_conflict <= w_accept & w_conflict;
            if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'h0001;
            end
        end
    end

    assign bus.stall           = w_stall;
    assign bus.fwd_sel         = w_fwd_sel;
    assign bus.bundle_conflict = r_conflict;
    assign bus.stall_cnt       = r_stall_cnt;

endmodule

// File: tb/tb_vliw_bypass_ctrl.sv
// Directed bench for vliw_bypass_ctrl with LANES=2, SRCS=2, DEPTH=2.
module tb_vliw_bypass_ctrl;

    logic clk;
    logic rst;

    int checks;
    int errors;

    vliw_bypass_ctrl_if #(.LANES(2), .SRCS(2), .DEPTH(2), .REG_AW(5)) bus ();

    vliw_bypass_ctrl #(.LANES(2), .SRCS(2), .DEPTH(2), .REG_AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic            rst;
        logic            valid;
        logic            flush;
        logic [3:0][4:0] rs;
        logic [3:0]      used;
        logic [1:0][4:0] rd;
        logic [1:0]      wr;
        logic [1:0]      ld;
        logic            exp_stall;
        logic [3:0][2:0] exp_sel;
        logic            exp_conf;
        logic [15:0]     exp_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic rs_rst, input logic valid, input logic flush,
        input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] r3,
        input logic [3:0] used, input logic [4:0] d0, input logic [4:0] d1,
        input logic [1:0] wr, input logic [1:0] ld, input logic est,
        input logic [2:0] s0, input logic [2:0] s1, input logic [2:0] s2, input logic [2:0] s3,
        input logic conf, input logic [15:0] cnt);
        vec_t v;
        v.rst = rs_rst; v.valid = valid; v.flush = flush;
        v.rs[0] = r0; v.rs[1] = r1; v.rs[2] = r2; v.rs[3] = r3;
        v.used = used; v.rd[0] = d0; v.rd[1] = d1; v.wr = wr; v.ld = ld;
        v.exp_stall = est;
        v.exp_sel[0] = s0; v.exp_sel[1] = s1; v.exp_sel[2] = s2; v.exp_sel[3] = s3;
        v.exp_conf = conf; v.exp_cnt = cnt;
        return v;
    endfunction

    task automatic checkOutput(input string name, input int idx,
                               input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst               = v.rst;
        bus.issue_valid   = v.valid;
        bus.flush         = v.flush;
        bus.issue_rs      = v.rs;
        bus.issue_rs_used = v.used;
        bus.issue_rd      = v.rd;
        bus.issue_wr      = v.wr;
        bus.issue_ld      = v.ld;
    endtask

    // Drive one cycle's inputs, check outputs mid-cycle, then advance past the next edge.
    task automatic runVector(input vec_t v, input int idx);
        applyStimulus(v);
        @(negedge clk);
        checkOutput("stall", idx, 16'(bus.stall), 16'(v.exp_stall));
        if (!v.exp_stall) begin
            for (int k = 0; k < 4; k++) begin
                checkOutput($sformatf("fwd_sel[%0d]", k), idx,
                            16'(bus.fwd_sel[k*3 +: 3]), 16'(v.exp_sel[k]));
            end
        end
        checkOutput("bundle_conflict", idx, 16'(bus.bundle_conflict), 16'(v.exp_conf));
        checkOutput("stall_cnt", idx, bus.stall_cnt, v.exp_cnt);
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        applyStimulus(mk(1,0,0, 0,0,0,0, 4'b0000, 0,0, 2'b00,2'b00, 0, 0,0,0,0, 0, 0));
        repeat (2) @(posedge clk);
        #1;

        // reset state
        vecs.push_back(mk(1,0,0, 0,0,0,0, 4'b0000, 0,0,   2'b00,2'b00, 0, 0,0,0,0, 0, 0));
        // EX lane1 forward
        vecs.push_back(mk(0,1,0, 0,0,0,0, 4'b0000, 0,5,   2'b10,2'b00, 0, 0,0,0,0, 0, 0));
        vecs.push_back(mk(0,1,0, 5,0,0,5, 4'b0001, 0,0,   2'b00,2'b00, 0, 2,0,0,0, 0, 0));
        // MEM lane1 for x5, then MEM lane0 / lane1 for x7
        vecs.push_back(mk(0,1,0, 0,0,5,0, 4'b0100, 7,0,   2'b01,2'b00, 0, 0,0,4,0, 0, 0));
        vecs.push_back(mk(0,0,0, 0,0,0,0, 4'b0000, 0,0,   2'b00,2'b00, 0, 0,0,0,0, 0, 0));
        vecs.push_back(mk(0,1,0, 0,7,0,0, 4'b0010, 0,7,   2'b10,2'b00, 0, 0,3,0,0, 0, 0));
        vecs.push_back(mk(0,0,0, 7,0,0,0, 4'b0001, 0,0,   2'b00,2'b00, 0, 2,0,0,0, 0, 0));
        vecs.push_back(mk(0,1,0, 0,0,0,7, 4'b1000, 0,0,   2'b00,2'b00, 0, 0,0,0,4, 0, 0));
        // load-use stall on x9
        vecs.push_back(mk(0,1,0, 0,0,0,0, 4'b0000, 9,0,   2'b01,2'b01, 0, 0,0,0,0, 0, 0));
        vecs.push_back(mk(0,1,0, 9,0,0,0, 4'b0001, 0,0,   2'b00,2'b00, 1, 0,0,0,0, 0, 0));
        vecs.push_back(mk(0,1,0, 9,0,0,0, 4'b0001, 0,0,   2'b00,2'b00, 0, 3,0,0,0, 0, 1));
        // same-bundle conflict on x3, x0 writes never forward
        vecs.push_back(mk(0,1,0, 0,0,0,0, 4'b0000, 3,3,   2'b11,2'b00, 0, 0,0,0,0, 0, 1));
        vecs.push_back(mk(0,1,0, 3,0,0,0, 4'b0001, 0,0,   2'b11,2'b00, 0, 2,0,0,0, 1, 1));
        vecs.push_back(mk(0,1,0, 0,0,3,0, 4'b0101, 0,0,   2'b00,2'b00, 0, 0,0,4,0, 0, 1));
        // flush beats stall on load x4
        vecs.push_back(mk(0,1,0, 0,0,0,0, 4'b0000, 4,0,   2'b01,2'b01, 0, 0,0,0,0, 0, 1));
        vecs.push_back(mk(0,1,1, 4,0,0,0, 4'b0001, 0,0,   2'b00,2'b00, 0, 1,0,0,0, 0, 1));
        vecs.push_back(mk(0,1,0, 4,0,0,0, 4'b0001, 0,0,   2'b00,2'b00, 0, 0,0,0,0, 0, 1));
        // reset with live entries
        vecs.push_back(mk(0,1,0, 0,0,0,0, 4'b0000, 10,11, 2'b11,2'b00, 0, 0,0,0,0, 0, 1));
        vecs.push_back(mk(0,1,0, 0,0,10,0,4'b0100, 12,0,  2'b01,2'b00, 0, 0,0,1,0, 0, 1));
        vecs.push_back(mk(1,1,0, 11,0,0,12,4'b1001,0,0,   2'b00,2'b00, 0, 0,0,0,0, 0, 1));
        vecs.push_back(mk(0,1,0, 10,11,12,0,4'b0111,0,0,  2'b00,2'b00, 0, 0,0,0,0, 0, 0));

        foreach (vecs[i]) begin
            runVector(vecs[i], i);
        end

        // Tie in EX: non-load lane1 beats load lane0, so no stall.
        runVector(mk(0,1,0, 0,0,0,0, 4'b0000, 6,6, 2'b11,2'b01, 0, 0,0,0,0, 0, 0), 100);
        runVector(mk(0,1,0, 0,6,0,0, 4'b0010, 0,0, 2'b00,2'b00, 0, 0,2,0,0, 1, 0), 101);
        // Tie in EX: load lane1 beats non-load lane0, so stall, then MEM lane1.
        runVector(mk(0,1,0, 0,0,0,0, 4'b0000, 8,8, 2'b11,2'b10, 0, 0,0,0,0, 0, 0), 102);
        runVector(mk(0,1,0, 0,0,8,0, 4'b0100, 0,0, 2'b00,2'b00, 1, 0,0,0,0, 1, 0), 103);
        runVector(mk(0,1,0, 0,0,8,0, 4'b0100, 0,0, 2'b00,2'b00, 0, 0,0,4,0, 0, 1), 104);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vliw_bypass_ctrl.md
VLIW_BYPASS_CTRL -- requirements
Module: vliw_bypass_ctrl

Interface
REQ-001 Parameter LANES, default 2: issue slots per bundle.
REQ-002 Parameter SRCS, default 2: source operands per lane.
REQ-003 Parameter DEPTH, default 2: in-flight bypass stages tracked (stage 1 = EX, stage DEPTH = oldest).
REQ-004 Parameter REG_AW, default 5: register address width.
REQ-005 Localparam SELW = clog2(LANES*DEPTH+1): forward-select width.
REQ-006 clk  in  1  the one clock; all state updates on its rising edge.
REQ-007 rst  in  1  reset, synchronous and active-high.
REQ-008 issue_valid  in  1  a bundle is presented for issue this cycle.
REQ-009 issue_rs  in  LANES*SRCS*REG_AW  source register addresses, lane-major.
REQ-010 issue_rs_used  in  LANES*SRCS  the source is actually read.
REQ-011 issue_rd  in  LANES*REG_AW  destination register per lane.
REQ-012 issue_wr  in  LANES  the lane writes issue_rd.
REQ-013 issue_ld  in  LANES  the lane is a load, so its data is late by one stage.
REQ-014 flush  in  1  kill the youngest in-flight bundle and the presented bundle.
REQ-015 stall  out  1  load-use hazard; the presented bundle is not accepted.
REQ-016 fwd_sel  out  LANES*SRCS*SELW  bypass source per operand.
REQ-017 bundle_conflict  out  1  registered pulse: two lanes of an accepted bundle wrote the same nonzero rd.
REQ-018 stall_cnt  out  16  saturating count of stall cycles.

Function
REQ-019 Internal state is a DEPTH-entry shift register; each entry holds a per-lane {wr, rd, ld}.
REQ-020 Every cycle all entries advance one stage; the stage-DEPTH entry is discarded.
REQ-021 When issue_valid=1, stall=0 and flush=0, stage 1 loads the presented bundle; otherwise stage 1 loads a bubble (all wr=0).
REQ-022 flush=1 clears the entry currently in stage 1 before the advance, so stage 2 receives a bubble; older stages are unaffected.
REQ-023 Operand match: issue_rs_used=1, rs!=0, entry wr=1 and entry rd==rs.
REQ-024 fwd_sel is combinational, valid in the issue cycle, and equals 0 (register file) when no entry matches.
REQ-025 Otherwise fwd_sel = 1 + (s-1)*LANES + l for the matching entry with the smallest stage s; ties within a stage go to the highest lane l.
REQ-026 With LANES=2 and DEPTH=2: 1 = EX lane0, 2 = EX lane1, 3 = MEM lane0, 4 = MEM lane1.
REQ-027 stall = issue_valid & ~flush & (any used operand whose selected match is a stage-1 entry with ld=1).
REQ-028 A stall lasts exactly one cycle per load, because the load moves to stage 2 where its data can be forwarded.
REQ-029 While stall=1, fwd_sel is don't-care and the issuer holds the bundle.
REQ-030 flush and stall asserted together: flush wins, stall=0, and nothing is accepted.
REQ-031 bundle_conflict is asserted on the cycle after an accepted bundle has two lanes with wr=1 and equal nonzero rd; the bundle is still accepted.
REQ-032 A later lane overrides an earlier lane (per REQ-025).
REQ-033 stall_cnt increments on each cycle with stall=1 and holds at 16'hFFFF.
REQ-034 Same-bundle dependencies are not forwarded.

Reset
REQ-035 When rst=1, all entries are cleared (wr=0, ld=0, rd=0), bundle_conflict=0 and stall_cnt=0 on the next edge.
REQ-036 Reset mid-operation discards all in-flight tags.
REQ-037 During reset, stall=0 and fwd_sel=0 because no entry matches.

Structure
REQ-038 Package vliw_pkg holds REG_AW, the constant FWD_RF=0 and the per-lane tag struct {wr, rd, ld}.
REQ-039 Sub-module fwd_match (one operand against DEPTH*LANES tags; outputs sel and a load-hit flag) is instantiated LANES*SRCS times.

Verification (LANES=2, SRCS=2, DEPTH=2)
REQ-040 Scenario: issue lane1 wr x5 (not a load); next cycle issue lane0 rs1=x5 -> fwd_sel=2, stall=0.
REQ-041 Scenario: issue lane0 wr x7; bubble; issue rs=x7 -> fwd_sel=3; repeat the same pattern from lane1 -> fwd_sel=4.
REQ-042 Scenario: issue lane0 load x9; next cycle issue rs=x9 -> stall=1 for one cycle, then fwd_sel=3 and the bundle is accepted; stall_cnt=1.
REQ-043 Scenario: both lanes write x3 in one bundle; next cycle read x3 -> fwd_sel=2 and bundle_conflict=1 for one cycle; x0 written by any lane -> fwd_sel=0.
REQ-044 Scenario: load x4 in stage 1 and flush=1 with a dependent bundle presented -> stall=0, the bundle is rejected, and the next cycle's read of x4 gives fwd_sel=0.
REQ-045 Scenario: rst asserted with two live entries -> after one edge, a read of their registers gives fwd_sel=0, and stall_cnt=0.
